pcie_cfg_tx: RTL and testbench
==============================

PCIE_CFG_TX -- requirements
Module: pcie_cfg_tx

Interface
REQ-001 SHALL have parameter REQ_ID, default 16'h0000, Requester ID placed in the TLP header.
REQ-002 SHALL have parameter TGT_BDF, default 16'h0100, target {bus[7:0],dev[4:0],func[2:0]}.
REQ-003 SHALL have port user_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port user_reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ctr2tx_type0_cfg_read  in  1  level request, held until done is seen.
REQ-006 SHALL have ports ctr2tx_type0_cfg_read_tag  in  8, ctr2tx_type0_cfg_read_reg_addr  in  12, and ctr2tx_type0_cfg_read_first_dw_be  in  4; these carry the request fields.
REQ-007 SHALL have port tx2ctr_type0_cfg_read_done  out  1  one-cycle pulse after the TLP is fully sent.
REQ-008 SHALL have ports m_axis_tx_tdata  out  64, m_axis_tx_tkeep  out  8, m_axis_tx_tlast  out  1, m_axis_tx_tvalid  out  1 and m_axis_tx_tready  in  1, forming the TLP stream.

Function
REQ-009 SHALL build a CfgRd0 TLP from three header DWs: DW0={fmt 3'b000, type 5'b00100, zeros, length 10'd1}; DW1={REQ_ID, tag, lastBE 4'h0, firstBE}; DW2={TGT_BDF, 4'h0, addr[11:8], addr[7:2], 2'b00}.
REQ-010 SHALL place lower DW in tdata[31:0]: beat0={DW1,DW0}, tkeep 8'hFF, tlast 0; beat1={32'h0,DW2}, tkeep 8'h0F, tlast 1.
REQ-011 SHALL use states IDLE, BEAT0, BEAT1, DONE and RELEASE.
REQ-012 SHALL, in IDLE with request high, capture tag/addr/BE and enter BEAT0; tvalid rises the next cycle, one cycle of latency.
REQ-013 SHALL hold tvalid, tdata, tkeep and tlast stable in BEAT0 and BEAT1 until tvalid&&tready; BEAT0 then goes to BEAT1, and BEAT1 then goes to DONE.
REQ-014 SHALL, in DONE, pulse done for exactly one cycle with tvalid low, then enter RELEASE.
REQ-015 SHALL stay in RELEASE until the request is low, then return to IDLE; a request still held after done SHALL never start a second TLP.
REQ-016 SHALL ignore request field changes after capture; the captured values are used.
REQ-017 SHALL, if tready is held low indefinitely, remain in its beat state with no timeout.
REQ-018 SHALL allow back-to-back requests with a minimum spacing of 5 cycles from one request start to the next with tready=1 (IDLE to RELEASE to IDLE).

Reset
REQ-019 SHALL, while user_reset is high, force state to IDLE, tvalid to 0, tlast to 0, tdata to 0, tkeep to 0, done to 0, and captured fields to 0, asynchronously.
REQ-020 SHALL, on reset during BEAT0 or BEAT1, drop the partial TLP and emit no done; after release it SHALL behave as in IDLE.

Configuration
REQ-021 SHALL compile Type0 config-write support only when PCIE_CFG_TX_CFG_WRITE_EN is defined.
REQ-022 SHALL, with PCIE_CFG_TX_CFG_WRITE_EN defined, add these ports:
- ctr2tx_type0_cfg_write  in  1
- ctr2tx_type0_cfg_write_data  in  32
- tx2ctr_type0_cfg_write_done  out  1
REQ-023 SHALL, with PCIE_CFG_TX_CFG_WRITE_EN defined, build a CfgWr0 TLP:
- DW0 uses fmt 3'b010.
- beat1 is {data,DW2} with tkeep 8'hFF.
- the same FSM and handshake rules apply, with its own done pulse.
REQ-024 SHALL, with PCIE_CFG_TX_CFG_WRITE_EN defined and read and write both requested in IDLE in the same cycle, serve the read first.
REQ-025 SHALL, without PCIE_CFG_TX_CFG_WRITE_EN, have no write ports and no write logic.

Structure
REQ-026 SHALL take the following from shared package pcie_tlp_pkg:
- fmt/type constants (FMT_3DW_NODATA, FMT_3DW_DATA, TYPE_CFG0)
- header field widths
- the state enumeration
REQ-027 SHALL implement header assembly in a single sub-module pcie_tlp_hdr_builder: captured fields plus parameters in, DW0..DW2 out, purely combinational.

Verification
REQ-028 SHALL check: read with tag 8'h00, addr 12'h080, BE 4'hF and tready=1 -> beat0 tdata 64'h0000000F_04000001, tkeep FF; beat1 tdata 64'h00000000_01000080, tkeep 0F, tlast 1; done one cycle later.
REQ-029 SHALL check: tready low for 10 cycles in BEAT0 and then for 3 cycles in BEAT1 -> outputs stable throughout, exactly 2 handshakes, exactly one done pulse.
REQ-030 SHALL check: request held 4 cycles past done -> no tvalid while in RELEASE; re-raising the request with tag 8'h05 -> DW1 = 32'h0000050F.
REQ-031 SHALL check: reset asserted in BEAT1 with tready=0 -> tvalid 0 immediately, no done; the next request gives a clean 2-beat TLP.
REQ-032 SHALL check (PCIE_CFG_TX_CFG_WRITE_EN defined): write with data 32'hDEADBEEF, addr 12'h004, BE 4'h1 -> beat0 64'h00000001_44000001; beat1 64'hDEADBEEF_01000004, tkeep FF; write_done pulse.
REQ-033 SHALL check (PCIE_CFG_TX_CFG_WRITE_EN defined): simultaneous read and write -> read TLP and read done first, then the write TLP after the read request is released.

Source files
------------

// File: rtl/pcie_tlp_pkg.sv
// Shared TLP definitions for the config-request transmitter: fmt/type
// constants, header field widths, FSM state encoding and the request capture
// record.
package pcie_tlp_pkg;

  localparam int DW_W   = 32;
  localparam int TAG_W  = 8;
  localparam int ADDR_W = 12;
  localparam int BE_W   = 4;
  localparam int BDF_W  = 16;
  localparam int LEN_W  = 10;

  localparam logic [2:0] FMT_3DW_NODATA = 3'b000;
  localparam logic [2:0] FMT_3DW_DATA   = 3'b010;
  localparam logic [4:0] TYPE_CFG0      = 5'b00100;

  typedef enum logic [2:0] {
    IDLE,
    BEAT0,
    BEAT1,
    DONE,
    RELEASE
  } cfg_state_t;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
  } cfg_req_t;

endpackage

// File: rtl/pcie_tlp_hdr_builder.sv
// Combinational 3DW Type0 configuration header assembly.
// Outputs DW0..DW2 from the captured request and the fixed IDs.
module pcie_tlp_hdr_builder
  import pcie_tlp_pkg::*;
#(
  parameter logic [BDF_W-1:0] REQ_ID  = 16'h0000,
  parameter logic [BDF_W-1:0] TGT_BDF = 16'h0100
) (
  input  logic [2:0]      fmt,
  input  cfg_req_t        req,
  output logic [DW_W-1:0] dw0,
  output logic [DW_W-1:0] dw1,
  output logic [DW_W-1:0] dw2
);

  // Config registers are DW-aligned; the byte offset bits never reach the header.
  logic unused_addr_lo;
  assign unused_addr_lo = ^req.addr[1:0];

  // Single-DW payload length, traffic class / attributes / digest all zero.
  assign dw0 = {fmt, TYPE_CFG0, 14'h0000, LEN_W'(1)};
  assign dw1 = {REQ_ID, req.tag, 4'h0, req.be};
  assign dw2 = {TGT_BDF, 4'h0, req.addr[11:8], req.addr[7:2], 2'b00};

endmodule

// File: rtl/pcie_cfg_tx.sv
// Type0 configuration request transmitter: turns a level request into a
// two-beat 3DW TLP on a 64-bit AXI-stream and answers with a done pulse.
// Optional config-write support is compiled in with PCIE_CFG_TX_CFG_WRITE_EN.
module pcie_cfg_tx
  import pcie_tlp_pkg::*;
#(
  parameter logic [BDF_W-1:0] REQ_ID  = 16'h0000,
  parameter logic [BDF_W-1:0] TGT_BDF = 16'h0100
) (
  input  logic              user_clk,
  input  logic              user_reset,
  input  logic              ctr2tx_type0_cfg_read,
  input  logic [TAG_W-1:0]  ctr2tx_type0_cfg_read_tag,
  input  logic [ADDR_W-1:0] ctr2tx_type0_cfg_read_reg_addr,
  input  logic [BE_W-1:0]   ctr2tx_type0_cfg_read_first_dw_be,
  output logic              tx2ctr_type0_cfg_read_done,
`ifdef PCIE_CFG_TX_CFG_WRITE_EN
  input  logic              ctr2tx_type0_cfg_write,
  input  logic [DW_W-1:0]   ctr2tx_type0_cfg_write_data,
  output logic              tx2ctr_type0_cfg_write_done,
`endif
  output logic [63:0]       m_axis_tx_tdata,
  output logic [7:0]        m_axis_tx_tkeep,
  output logic              m_axis_tx_tlast,
  output logic              m_axis_tx_tvalid,
  input  logic              m_axis_tx_tready
);

  cfg_state_t      state, state_nxt;
  cfg_req_t        cap;
  logic            start;
  logic            req_held;
  logic            done_pulse;
  logic [2:0]      fmt;
  logic [DW_W-1:0] dw0, dw1, dw2;
  logic [63:0]     beat1_data;
  logic [7:0]      beat1_keep;

`ifdef PCIE_CFG_TX_CFG_WRITE_EN
  logic            cap_wr;
  logic [DW_W-1:0] cap_data;

  // Read wins a same-cycle tie; the write stays pending until the read is released.
  assign start      = ctr2tx_type0_cfg_read | ctr2tx_type0_cfg_write;
  assign req_held   = cap_wr ? ctr2tx_type0_cfg_write : ctr2tx_type0_cfg_read;
  assign fmt        = cap_wr ? FMT_3DW_DATA : FMT_3DW_NODATA;
  assign beat1_data = cap_wr ? {cap_data, dw2} : {32'h0, dw2};
  assign beat1_keep = cap_wr ? 8'hFF : 8'h0F;
  assign tx2ctr_type0_cfg_read_done  = done_pulse & ~cap_wr;
  assign tx2ctr_type0_cfg_write_done = done_pulse & cap_wr;
`else
  assign start      = ctr2tx_type0_cfg_read;
  assign req_held   = ctr2tx_type0_cfg_read;
  assign fmt        = FMT_3DW_NODATA;
  assign beat1_data = {32'h0, dw2};
  assign beat1_keep = 8'h0F;
  assign tx2ctr_type0_cfg_read_done = done_pulse;
`endif

  // Latch request fields once in IDLE so later input changes cannot corrupt the TLP.
  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      cap      <= '0;
`ifdef PCIE_CFG_TX_CFG_WRITE_EN
      cap_wr   <= 1'b0;
      cap_data <= '0;
`endif
    end else if (state == IDLE && start) begin
      cap <= '{tag:  ctr2tx_type0_cfg_read_tag,
               addr: ctr2tx_type0_cfg_read_reg_addr,
               be:   ctr2tx_type0_cfg_read_first_dw_be};
`ifdef PCIE_CFG_TX_CFG_WRITE_EN
      cap_wr   <= ~ctr2tx_type0_cfg_read;
      cap_data <= ctr2tx_type0_cfg_write_data;
`endif
    end
  end

  pcie_tlp_hdr_builder #(
    .REQ_ID  (REQ_ID),
    .TGT_BDF (TGT_BDF)
  ) u_hdr (
    .fmt (fmt),
    .req (cap),
    .dw0 (dw0),
    .dw1 (dw1),
    .dw2 (dw2)
  );

  // State register; reset drops any partial TLP.
  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next state and stream outputs; data is a pure function of state so it holds while stalled.
  always_comb begin
    state_nxt        = state;
    m_axis_tx_tvalid = 1'b0;
    m_axis_tx_tlast  = 1'b0;
    m_axis_tx_tkeep  = 8'h00;
    m_axis_tx_tdata  = 64'h0;
    done_pulse       = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = BEAT0;
      BEAT0: begin
        m_axis_tx_tvalid = 1'b1;
        m_axis_tx_tdata  = {dw1, dw0};
        m_axis_tx_tkeep  = 8'hFF;
        if (m_axis_tx_tready) state_nxt = BEAT1;
      end
      BEAT1: begin
        m_axis_tx_tvalid = 1'b1;
        m_axis_tx_tdata  = beat1_data;
        m_axis_tx_tkeep  = beat1_keep;
        m_axis_tx_tlast  = 1'b1;
        if (m_axis_tx_tready) state_nxt = DONE;
      end
      DONE: begin
        done_pulse = 1'b1;
        state_nxt  = RELEASE;
      end
      // A still-held request must not launch a second TLP.
      RELEASE: if (!req_held) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pcie_cfg_tx.sv
// Scoreboard bench for pcie_cfg_tx: stimulus pushes hand-computed beats and
// done events; a negedge monitor compares every presented beat and done pulse.
module tb_pcie_cfg_tx;

  logic        user_clk = 1'b0;
  logic        user_reset = 1'b1;
  logic        rd = 1'b0;
  logic [7:0]  tag = 8'h00;
  logic [11:0] addr = 12'h000;
  logic [3:0]  be = 4'h0;
  logic        rd_done;
  logic        wr_done;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast, tvalid;
  logic        tready = 1'b0;
`ifdef PCIE_CFG_TX_CFG_WRITE_EN
  logic        wr = 1'b0;
  logic [31:0] wdata = 32'h0;
`endif

  always #5 user_clk = ~user_clk;

  pcie_cfg_tx dut (
    .user_clk                          (user_clk),
    .user_reset                        (user_reset),
    .ctr2tx_type0_cfg_read             (rd),
    .ctr2tx_type0_cfg_read_tag         (tag),
    .ctr2tx_type0_cfg_read_reg_addr    (addr),
    .ctr2tx_type0_cfg_read_first_dw_be (be),
    .tx2ctr_type0_cfg_read_done        (rd_done),
`ifdef PCIE_CFG_TX_CFG_WRITE_EN
    .ctr2tx_type0_cfg_write            (wr),
    .ctr2tx_type0_cfg_write_data       (wdata),
    .tx2ctr_type0_cfg_write_done       (wr_done),
`endif
    .m_axis_tx_tdata                   (tdata),
    .m_axis_tx_tkeep                   (tkeep),
    .m_axis_tx_tlast                   (tlast),
    .m_axis_tx_tvalid                  (tvalid),
    .m_axis_tx_tready                  (tready)
  );
`ifndef PCIE_CFG_TX_CFG_WRITE_EN
  assign wr_done = 1'b0;
`endif

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  bit    done_q[$];
  int    pass_cnt = 0, chk_cnt = 0;
  int    hs_cnt = 0, done_cnt = 0, cyc = 0, last_hs_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(posedge user_clk) cyc <= cyc + 1;

  // Monitor: compare every presented beat against the queue head; pop on handshake.
  always @(negedge user_clk) begin
    if (!user_reset) begin
      if (tvalid) begin
        if (exp_q.size() == 0) chk("unexp_valid", tvalid, 0);
        else begin
          chk("tdata", tdata, exp_q[0].data);
          chk("tkeep", tkeep, exp_q[0].keep);
          chk("tlast", tlast, exp_q[0].last);
          if (tready) begin
            if (tlast) last_hs_cyc = cyc;
            void'(exp_q.pop_front());
            hs_cnt++;
          end
        end
      end
      if (rd_done || wr_done) begin
        if (done_q.size() == 0) chk("unexp_done", {rd_done, wr_done}, 0);
        else begin
          bit w;
          w = done_q.pop_front();
          chk("done_kind", {rd_done, wr_done}, w ? 2'b01 : 2'b10);
          chk("done_lat", cyc, last_hs_cyc + 1);
          chk("done_tvalid", tvalid, 0);
        end
        done_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic expect_tlp(input logic [63:0] b0, input logic [63:0] b1,
                            input logic [7:0] k1, input bit w);
    beat_t b;
    b.data = b0; b.keep = 8'hFF; b.last = 1'b0; exp_q.push_back(b);
    b.data = b1; b.keep = k1;    b.last = 1'b1; exp_q.push_back(b);
    done_q.push_back(w);
  endtask

  task automatic wait_done(input int n0, input string name);
    int k = 0;
    while (done_cnt == n0 && k < 200) begin
      @(posedge user_clk);
      k++;
    end
    chk(name, done_cnt, n0 + 1);
    #1;
  endtask

  task automatic hold_check(input int n);
    repeat (n) begin
      @(negedge user_clk);
      chk("rel_tvalid", tvalid, 0);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n0, h0;
    // Reset state
    repeat (3) @(posedge user_clk);
    @(negedge user_clk);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tkeep", tkeep, 0);
    chk("rst_done", rd_done, 0);
    tick();
    user_reset = 1'b0;
    tick();

    // Basic read, one-cycle latency, field changes after capture ignored
    tready = 1'b1;
    expect_tlp(64'h0000000F_04000001, 64'h00000000_01000080, 8'h0F, 0);
    n0 = done_cnt;
    tag = 8'h00; addr = 12'h080; be = 4'hF; rd = 1'b1;
    @(negedge user_clk);
    chk("lat_before", tvalid, 0);
    @(negedge user_clk);
    chk("lat_after", tvalid, 1);
    tag = 8'hFF; addr = 12'hFFF; be = 4'h0;
    wait_done(n0, "basic_done");
    rd = 1'b0;
    tick(); tick();

    // Backpressure: 10 stalled cycles in BEAT0, 3 in BEAT1
    tready = 1'b0;
    expect_tlp(64'h00000103_04000001, 64'h00000000_01000010, 8'h0F, 0);
    n0 = done_cnt; h0 = hs_cnt;
    tag = 8'h01; addr = 12'h010; be = 4'h3; rd = 1'b1;
    tick();
    repeat (10) tick();
    tready = 1'b1;
    tick();
    tready = 1'b0;
    repeat (3) tick();
    tready = 1'b1;
    wait_done(n0, "stall_done");
    repeat (3) tick();
    chk("stall_hs", hs_cnt - h0, 2);
    chk("stall_done_cnt", done_cnt - n0, 1);
    rd = 1'b0;
    tick(); tick();

    // Request held past done, then a fresh request with tag 05
    expect_tlp(64'h0000000F_04000001, 64'h00000000_01000080, 8'h0F, 0);
    n0 = done_cnt;
    tag = 8'h00; addr = 12'h080; be = 4'hF; rd = 1'b1;
    wait_done(n0, "hold_done");
    hold_check(4);
    rd = 1'b0;
    tick();
    expect_tlp(64'h0000050F_04000001, 64'h00000000_01000080, 8'h0F, 0);
    n0 = done_cnt;
    tag = 8'h05; rd = 1'b1;
    wait_done(n0, "tag5_done");
    rd = 1'b0;
    tick(); tick();

    // Reset while stalled in BEAT1
    tready = 1'b0;
    expect_tlp(64'h0000070F_04000001, 64'h00000000_01000080, 8'h0F, 0);
    tag = 8'h07; rd = 1'b1;
    tick();
    tready = 1'b1;
    tick();
    tready = 1'b0;
    tick();
    user_reset = 1'b1;
    #1;
    chk("mid_rst_tvalid", tvalid, 0);
    chk("mid_rst_tlast", tlast, 0);
    chk("mid_rst_tdata", tdata, 0);
    exp_q.delete();
    done_q.delete();
    n0 = done_cnt;
    rd = 1'b0;
    tick(); tick();
    user_reset = 1'b0;
    repeat (5) tick();
    chk("rst_no_done", done_cnt, n0);
    tready = 1'b1;
    expect_tlp(64'h0000080F_04000001, 64'h00000000_01000080, 8'h0F, 0);
    tag = 8'h08; rd = 1'b1;
    wait_done(n0, "post_rst_done");
    rd = 1'b0;
    tick(); tick();

`ifdef PCIE_CFG_TX_CFG_WRITE_EN
    // Config write
    expect_tlp(64'h00000001_44000001, 64'hDEADBEEF_01000004, 8'hFF, 1);
    n0 = done_cnt;
    tag = 8'h00; addr = 12'h004; be = 4'h1; wdata = 32'hDEADBEEF; wr = 1'b1;
    wait_done(n0, "wr_done");
    wr = 1'b0;
    tick(); tick();

    // Simultaneous read and write: read first, write after read release
    expect_tlp(64'h0000030F_04000001, 64'h00000000_01000080, 8'h0F, 0);
    expect_tlp(64'h0000030F_44000001, 64'h12345678_01000080, 8'hFF, 1);
    n0 = done_cnt;
    tag = 8'h03; addr = 12'h080; be = 4'hF; wdata = 32'h12345678;
    rd = 1'b1; wr = 1'b1;
    wait_done(n0, "both_rd_done");
    tick(); tick();
    rd = 1'b0;
    wait_done(n0 + 1, "both_wr_done");
    wr = 1'b0;
    tick(); tick();
`endif

    repeat (3) tick();
    chk("exp_q_empty", exp_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
